// File: rtl/alu_issue_ctrl.sv
// alu_issue_ctrl: issue/writeback controller for the 16-bit combinational ALU.
// Accepts one instruction per handshake and reads two operands from an
// internal register file, in which r0 always reads as zero. It drives the
// ALU, captures the result and flags, and writes the result back.
// Only one instruction is in flight, sequenced IDLE -> ISSUE -> EXEC -> WB.
module alu_issue_ctrl #(
    parameter int NREGS  = 8,
    parameter int DATA_W = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [15:0]              instr,
    input  logic                     instr_valid,
    output logic                     instr_ready,
    input  logic                     ld_en,
    input  logic [$clog2(NREGS)-1:0] ld_addr,
    input  logic [DATA_W-1:0]        ld_data,
    output logic [DATA_W-1:0]        A,
    output logic [DATA_W-1:0]        B,
    output logic [3:0]               opcode_ALU,
    output logic [1:0]               alu_mode,
    input  logic [31:0]              Alu_out,
    input  logic                     C,
    input  logic                     Z,
    input  logic                     EQ,
    input  logic                     GT,
    input  logic                     ZA,
    input  logic                     ZB,
    output logic [5:0]               flags,
    output logic                     done,
    output logic                     err,
    input  logic [$clog2(NREGS)-1:0] dbg_addr,
    output logic [DATA_W-1:0]        dbg_data
);

    localparam int AW = $clog2(NREGS);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_EXEC,
        S_WB
    } state_t;

    state_t            state;
    state_t            state_nxt;

    logic [DATA_W-1:0] rf [NREGS];

    logic [1:0]        mode_q;
    logic [3:0]        opc_q;
    logic [AW-1:0]     rd_q;
    logic [AW-1:0]     rs1_q;
    logic [AW-1:0]     rs2_q;

    logic [DATA_W-1:0] rs1_val;
    logic [DATA_W-1:0] rs2_val;
    logic [DATA_W-1:0] res_q;
    logic [5:0]        flg_q;

    logic              hs;
    logic              ld_ok;
    logic              reject;
    logic              wb_en;

    logic [31-DATA_W:0] unused_alu_hi;
    logic               unused_rsvd;

    assign unused_alu_hi = Alu_out[31:DATA_W];
    assign unused_rsvd   = instr[0];

    assign hs    = instr_valid && instr_ready;
    assign ld_ok = (state == S_IDLE) && ld_en && (ld_addr != '0);
    assign wb_en = (state == S_WB) && !reject;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic: fixed four-step sequence, leaving IDLE on a handshake
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (hs) state_nxt = S_ISSUE;
            S_ISSUE: state_nxt = S_EXEC;
            S_EXEC:  state_nxt = S_WB;
            S_WB:    state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // FSM outputs: ready only in IDLE and never while reset is asserted
    always_comb begin
        instr_ready = 1'b0;
        done        = 1'b0;
        err         = 1'b0;
        case (state)
            S_IDLE:  instr_ready = rst_n;
            S_WB: begin
                done = 1'b1;
                err  = reject;
            end
            default: ;
        endcase
    end

    // Rejection check, evaluated on the operands and opcode currently driven to the ALU
    always_comb begin
        reject = 1'b0;
        if (alu_mode == 2'b11) begin
            reject = 1'b1;
        end else if (alu_mode == 2'b00) begin
            case (opcode_ALU)
                4'b0001, 4'b0010, 4'b1000: reject = 1'b0;
                4'b0100:                   reject = (B == '0);
                default:                   reject = 1'b1;
            endcase
        end
    end

    // Instruction field latch on the accepting handshake
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mode_q <= '0;
            opc_q  <= '0;
            rd_q   <= '0;
            rs1_q  <= '0;
            rs2_q  <= '0;
        end else if (hs) begin
            mode_q <= instr[15:14];
            opc_q  <= instr[13:10];
            rd_q   <= instr[9:7];
            rs1_q  <= instr[6:4];
            rs2_q  <= instr[3:1];
        end
    end

    // Register file reads with r0 hardwired to zero
    always_comb begin
        rs1_val  = (rs1_q == '0)    ? '0 : rf[rs1_q];
        rs2_val  = (rs2_q == '0)    ? '0 : rf[rs2_q];
        dbg_data = (dbg_addr == '0) ? '0 : rf[dbg_addr];
    end

    // ALU drive registers: loaded in ISSUE, held otherwise; mode 11 at reset keeps the ALU output at zero
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            A          <= '0;
            B          <= '0;
            opcode_ALU <= '0;
            alu_mode   <= 2'b11;
        end else if (state == S_ISSUE) begin
            A          <= rs1_val;
            B          <= rs2_val;
            opcode_ALU <= opc_q;
            alu_mode   <= mode_q;
        end
    end

    // Result and flag capture at the end of EXEC
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            res_q <= '0;
            flg_q <= '0;
        end else if (state == S_EXEC) begin
            res_q <= Alu_out[DATA_W-1:0];
            flg_q <= {C, Z, EQ, GT, ZA, ZB};
        end
    end

    // Architectural flags update only on an accepted writeback
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            flags <= '0;
        end else if (wb_en) begin
            flags <= flg_q;
        end
    end

    // Register file writes: preload in IDLE, writeback in WB; r0 writes dropped
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < unsigned'(NREGS); i++) begin
                rf[i] <= '0;
            end
        end else begin
            if (ld_ok) begin
                rf[ld_addr] <= ld_data;
            end
            if (wb_en && (rd_q != '0)) begin
                rf[rd_q] <= res_q;
            end
        end
    end

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// tb_alu_issue_ctrl: directed bench for alu_issue_ctrl with a small behavioural ALU.
module tb_alu_issue_ctrl;

    logic        clk;
    logic        rst_n;
    logic [15:0] instr;
    logic        instr_valid;
    logic        instr_ready;
    logic        ld_en;
    logic [2:0]  ld_addr;
    logic [15:0] ld_data;
    logic [15:0] A;
    logic [15:0] B;
    logic [3:0]  opcode_ALU;
    logic [1:0]  alu_mode;
    logic [31:0] Alu_out;
    logic        C, Z, EQ, GT, ZA, ZB;
    logic [5:0]  flags;
    logic        done;
    logic        err;
    logic [2:0]  dbg_addr;
    logic [15:0] dbg_data;

    int total = 0;
    int bad   = 0;

    logic [16:0] alu_s;

    alu_issue_ctrl #(
        .NREGS  (8),
        .DATA_W (16)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .instr       (instr),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .ld_en       (ld_en),
        .ld_addr     (ld_addr),
        .ld_data     (ld_data),
        .A           (A),
        .B           (B),
        .opcode_ALU  (opcode_ALU),
        .alu_mode    (alu_mode),
        .Alu_out     (Alu_out),
        .C           (C),
        .Z           (Z),
        .EQ          (EQ),
        .GT          (GT),
        .ZA          (ZA),
        .ZB          (ZB),
        .flags       (flags),
        .done        (done),
        .err         (err),
        .dbg_addr    (dbg_addr),
        .dbg_data    (dbg_data)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Behavioural ALU: mode 11 forces zero; AU opcodes add/mul/div/sub
    always_comb begin
        alu_s   = '0;
        Alu_out = '0;
        C       = 1'b0;
        if (alu_mode != 2'b11) begin
            case (opcode_ALU)
                4'b0001: begin
                    alu_s   = {1'b0, A} + {1'b0, B};
                    Alu_out = {16'h0, alu_s[15:0]};
                    C       = alu_s[16];
                end
                4'b1000: begin
                    alu_s   = {1'b0, A} - {1'b0, B};
                    Alu_out = {16'h0, alu_s[15:0]};
                    C       = alu_s[16];
                end
                4'b0010: Alu_out = A * B;
                4'b0100: Alu_out = (B != 16'h0) ? {16'h0, A / B} : 32'h0;
                default: ;
            endcase
        end
        Z  = (Alu_out[15:0] == 16'h0);
        EQ = (A == B);
        GT = (A > B);
        ZA = (A == 16'h0);
        ZB = (B == 16'h0);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_reg(input string tag, input logic [2:0] a, input logic [15:0] exp);
        dbg_addr = a;
        #1;
        chk(tag, {16'h0, dbg_data}, {16'h0, exp});
    endtask

    task automatic preload(input logic [2:0] a, input logic [15:0] d);
        ld_en   = 1'b1;
        ld_addr = a;
        ld_data = d;
        @(posedge clk);
        #1;
        ld_en   = 1'b0;
    endtask

    // Handshake one instruction and check the ISSUE/EXEC/WB/IDLE timeline
    task automatic run_instr(input string tag, input logic [15:0] ins, input logic exp_err);
        instr       = ins;
        instr_valid = 1'b1;
        chk({tag, "_rdy_idle"}, {31'h0, instr_ready}, 32'h1);
        @(posedge clk);
        #1;
        instr_valid = 1'b0;
        ld_en       = 1'b0;
        chk({tag, "_issue_rdy"},  {31'h0, instr_ready}, 32'h0);
        chk({tag, "_issue_done"}, {31'h0, done},        32'h0);
        @(posedge clk);
        #1;
        chk({tag, "_exec_done"},  {31'h0, done},        32'h0);
        @(posedge clk);
        #1;
        chk({tag, "_wb_done"},    {31'h0, done},        32'h1);
        chk({tag, "_wb_err"},     {31'h0, err},         {31'h0, exp_err});
        chk({tag, "_wb_rdy"},     {31'h0, instr_ready}, 32'h0);
        @(posedge clk);
        #1;
        chk({tag, "_post_done"},  {31'h0, done},        32'h0);
        chk({tag, "_post_rdy"},   {31'h0, instr_ready}, 32'h1);
    endtask

    initial begin
        rst_n       = 1'b0;
        instr       = '0;
        instr_valid = 1'b0;
        ld_en       = 1'b0;
        ld_addr     = '0;
        ld_data     = '0;
        dbg_addr    = '0;

        // Reset state
        #12;
        chk("rst_rdy",   {31'h0, instr_ready}, 32'h0);
        chk("rst_A",     {16'h0, A},           32'h0);
        chk("rst_B",     {16'h0, B},           32'h0);
        chk("rst_opc",   {28'h0, opcode_ALU},  32'h0);
        chk("rst_mode",  {30'h0, alu_mode},    32'h3);
        chk("rst_flags", {26'h0, flags},       32'h0);
        chk("rst_done",  {31'h0, done},        32'h0);
        chk("rst_err",   {31'h0, err},         32'h0);
        #5;
        rst_n = 1'b1;
        #1;
        chk("rel_rdy", {31'h0, instr_ready}, 32'h1);

        // Preload, including a dropped write to r0
        preload(3'd1, 16'h0005);
        preload(3'd2, 16'h0003);
        preload(3'd0, 16'hFFFF);
        chk_reg("pre_r1", 3'd1, 16'h0005);
        chk_reg("pre_r0", 3'd0, 16'h0000);

        // add r3 = r1 + r2
        run_instr("add", 16'h0594, 1'b0);
        chk_reg("add_r3", 3'd3, 16'h0008);
        chk("add_flags", {26'h0, flags},      32'h04);
        chk("add_Ahold", {16'h0, A},          32'h5);
        chk("add_Bhold", {16'h0, B},          32'h3);
        chk("add_opc",   {28'h0, opcode_ALU}, 32'h1);

        // sub r4 = r1 - r2, then zero result
        run_instr("sub", 16'h2214, 1'b0);
        chk_reg("sub_r4", 3'd4, 16'h0002);
        chk("sub_flags", {26'h0, flags}, 32'h04);
        preload(3'd1, 16'h0003);
        run_instr("subz", 16'h2214, 1'b0);
        chk_reg("subz_r4", 3'd4, 16'h0000);
        chk("subz_flags", {26'h0, flags}, 32'h18);

        // Divide by zero: rejected, r3 and flags unchanged
        run_instr("div0", 16'h1190, 1'b1);
        chk_reg("div0_r3", 3'd3, 16'h0008);
        chk("div0_flags", {26'h0, flags}, 32'h18);

        // Invalid mode and invalid AU opcode (the latter targets r1)
        run_instr("mode3", 16'hC594, 1'b1);
        chk_reg("mode3_r3", 3'd3, 16'h0008);
        run_instr("opc3", 16'h0C94, 1'b1);
        chk_reg("opc3_r1", 3'd1, 16'h0003);
        chk("opc3_flags", {26'h0, flags}, 32'h18);

        // Preload r5 in the same cycle as the handshake of r6 = r5 + r2
        ld_en   = 1'b1;
        ld_addr = 3'd5;
        ld_data = 16'h0010;
        run_instr("ldhs", 16'h0754, 1'b0);
        chk_reg("ldhs_r6", 3'd6, 16'h0013);

        // Back-to-back with instr_valid held: r3 = r1 + r2, then r7 = r3 + r2
        @(posedge clk);
        #1;
        instr       = 16'h0594;
        instr_valid = 1'b1;
        @(posedge clk);
        #1;
        chk("bp_issue_rdy", {31'h0, instr_ready}, 32'h0);
        instr = 16'h07B4;
        @(posedge clk);
        #1;
        chk("bp_exec_rdy", {31'h0, instr_ready}, 32'h0);
        ld_en   = 1'b1;
        ld_addr = 3'd2;
        ld_data = 16'hAAAA;
        @(posedge clk);
        #1;
        ld_en = 1'b0;
        chk("bp_wb_rdy",  {31'h0, instr_ready}, 32'h0);
        chk("bp_wb_done", {31'h0, done},        32'h1);
        chk("bp_wb_err",  {31'h0, err},         32'h0);
        @(posedge clk);
        #1;
        chk("bp_idle_rdy", {31'h0, instr_ready}, 32'h1);
        chk_reg("bp_r3", 3'd3, 16'h0006);
        chk_reg("bp_r2", 3'd2, 16'h0003);
        @(posedge clk);
        #1;
        instr_valid = 1'b0;
        chk("bp2_issue_rdy", {31'h0, instr_ready}, 32'h0);
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        chk("bp2_wb_done", {31'h0, done}, 32'h1);
        @(posedge clk);
        #1;
        chk_reg("bp2_r7", 3'd7, 16'h0009);
        chk("bp2_flags", {26'h0, flags}, 32'h04);

        // Reset during EXEC aborts the writeback and clears the register file
        preload(3'd1, 16'h0005);
        instr       = 16'h0594;
        instr_valid = 1'b1;
        @(posedge clk);
        #1;
        instr_valid = 1'b0;
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mr_done", {31'h0, done},        32'h0);
        chk("mr_rdy",  {31'h0, instr_ready}, 32'h0);
        chk("mr_mode", {30'h0, alu_mode},    32'h3);
        @(posedge clk);
        #1;
        chk("mr_done2", {31'h0, done}, 32'h0);
        rst_n = 1'b1;
        #1;
        chk("mr_rel_rdy", {31'h0, instr_ready}, 32'h1);
        for (int i = 0; i < 8; i++) begin
            logic [2:0] ra;
            ra = i[2:0];
            chk_reg($sformatf("mr_r%0d", i), ra, 16'h0000);
        end
        @(posedge clk);
        #1;
        chk("mr_done3", {31'h0, done}, 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/alu_issue_ctrl.md
Name: alu_issue_ctrl

Overview:
Issue/writeback controller on the driving side of the 16-bit CPU's combinational ALU. It accepts one 16-bit ALU instruction per valid/ready handshake and reads two operands from an internal 8x16 register file. It drives A, B, opcode_ALU and alu_mode to the ALU, samples the ALU result and flags, then writes the result back to the destination register. One instruction is in flight at a time, as a 4-state FSM.

Parameters:
NREGS, 8, register-file depth (address width = clog2(NREGS) = 3; instruction format fixed for 8).
DATA_W, 16, register/operand width.

Ports:
clk  input  1  system clock, rising edge.
rst_n  input  1  asynchronous, active-low reset.
instr  input  16  instruction: [15:14] alu_mode, [13:10] opcode, [9:7] rd, [6:4] rs1, [3:1] rs2, [0] reserved (ignored).
instr_valid  input  1  instr is valid.
instr_ready  output  1  controller can accept instr.
ld_en  input  1  register preload strobe (host/bench).
ld_addr  input  3  preload address.
ld_data  input  16  preload data.
A  output  16  ALU operand A.
B  output  16  ALU operand B.
opcode_ALU  output  4  ALU opcode.
alu_mode  output  2  ALU mode.
Alu_out  input  32  ALU result; bits [15:0] are used.
C, Z, EQ, GT, ZA, ZB  input  1 each  ALU flags.
flags  output  6  latched {C,Z,EQ,GT,ZA,ZB}.
done  output  1  one-cycle pulse at writeback.
err  output  1  one-cycle pulse with done for a rejected instruction.
dbg_addr  input  3  debug read address.
dbg_data  output  16  combinational read of regfile[dbg_addr].

Behaviour:
- Reset (async, rst_n=0): state=IDLE; all registers = 0; A=B=0; opcode_ALU=0; alu_mode=2'b11 (ALU output forced to 0); flags=0; done=err=0; instr_ready=0 while in reset, 1 on the first cycle after release.
- r0 is hardwired to 0: writes to r0 (preload or writeback) are dropped, and a read of r0 returns 0.
- States: IDLE -> ISSUE -> EXEC -> WB -> IDLE.
- IDLE: instr_ready=1. When instr_valid && instr_ready, latch instr and go to ISSUE. ld_en is honoured only in IDLE; ld_en in any other state is ignored. If ld_en and an instruction handshake occur in the same cycle, both take effect; the preload value is visible to that instruction's operand read.
- ISSUE: instr_ready=0. Register A<=reg[rs1], B<=reg[rs2], opcode_ALU<=opcode, alu_mode<=mode. Go to EXEC.
- EXEC: ALU inputs stay stable. At the end of the cycle, capture Alu_out[15:0] and the six flags into holding registers. Go to WB.
- WB: evaluate rejection:
  - mode==2'b11 -> reject.
  - mode==2'b00 with opcode not one-hot in {0001,0010,0100,1000} -> reject.
  - mode==2'b00 && opcode==4'b0100 && B==0 (divide by zero) -> reject.
- WB, accepted instruction: reg[rd]<=captured result; flags<=captured flags; done=1.
- WB, rejected instruction: no register write; flags unchanged; done=1 and err=1.
- WB, all cases: go to IDLE; instr_ready returns to 1 the following cycle.
- Latency: handshake at edge N -> done high during cycle N+3. Maximum throughput is one instruction per 4 cycles.
- A/B/opcode_ALU/alu_mode hold their last values in IDLE (no toggling).
- A write to rd lands at the WB edge. dbg_data reflects it from the next cycle.
- Self-dependency (rd==rs1 or rd==rs2) is safe: operands are latched in ISSUE.
- Reset asserted in any state aborts the operation: no writeback and no done, and the register file is cleared.

Test Plan:
- Preload r1=0x0005, r2=0x0003; instr=0x0594 (add, rd=r3) -> done at accept+3, err=0, dbg r3=0x0008, flags Z=0.
- Same preload; instr=0x2214 (sub, rd=r4) -> r4=0x0002. Then preload r1=0x0003 and issue 0x2214 -> r4=0x0000, flags Z=1.
- Divide by zero: instr=0x1190 (div r1/r0, rd=r3) -> done=1 and err=1 in the same cycle; r3 unchanged; flags unchanged.
- Invalid mode: instr=0xC594 -> err=1 and no write. Invalid AU opcode 0x0C94 (opcode 0011) -> err=1.
- Backpressure: hold instr_valid=1 with two back-to-back instructions -> instr_ready=0 for 3 cycles after each accept; the second is accepted the cycle after the first done; ld_en pulsed during EXEC is ignored.
- Reset mid-op: drop rst_n during EXEC of 0x0594 -> immediately IDLE, done never pulses, r3=0 and all regs 0; after release instr_ready=1.
